// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the uart_component peripheral: register addresses,
// status register bit positions, interrupt ID encodings and the state
// encoding used by both the receiver and the transmitter.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Register addresses (addr 3..7 are unmapped)
  localparam logic [2:0] UART_CTRL = 3'd0;
  localparam logic [2:0] UART_RX   = 3'd1;
  localparam logic [2:0] UART_TX   = 3'd2;

  // Status / control register bit positions
  localparam int ST_RX_READY  = 0;
  localparam int ST_TX_BUSY   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_RX_IE     = 4;
  localparam int ST_TX_IE     = 5;

  // Interrupt source IDs
  localparam logic [2:0] IRQ_NONE = 3'd0;
  localparam logic [2:0] IRQ_RX   = 3'd1;
  localparam logic [2:0] IRQ_TX   = 3'd2;
  localparam logic [2:0] IRQ_ERR  = 3'd3;

  // Frame state, shared by RX and TX
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver: 2-flop synchronizer, falling-edge start detect,
// start bit re-check at DIV/2, then one sample per bit every DIV clocks.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   rx_i         serial input, idle high
//   byte_o       last assembled byte (valid when valid_o pulses)
//   valid_o      one-cycle pulse: byte received with a good stop bit
//   frame_err_o  one-cycle pulse: stop bit sampled low, byte discarded
//   state_o      current receiver state
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 417
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output uart_state_e state_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  logic rx_s;
  logic fall;
  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        // Mid-start re-check: a high line here was only a glitch
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) valid_d = 1'b1;
          else      ferr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/uart_component.sv
// ---------------------------------------------------------------------------
// uart_component
// Memory-mapped 8N1 UART: control/status, RX buffer and TX buffer registers,
// a one-cycle read handshake and a registered level interrupt with source ID.
// Build option: define UART_DEBUG_EN to drive the registered debug bus
// {rx_state, tx_state, overrun, frame_err, tx_busy, rx_ready}; otherwise
// debug is tied to zero.
//
// Ports:
//   clock      sole clock
//   reset      asynchronous, active-low
//   cs         chip select, active-low
//   wr         write enable, active-low (one write per cs&wr low pulse)
//   rd_strobe  read request; cs=0, wr=1 required
//   rd_busy    high for the cycle after a read is accepted
//   addr       register select
//   in_data    write data
//   out_data   read data, held until the next read
//   rx_in      serial input, idle high
//   tx_out     serial output, idle high
//   irq        level interrupt
//   irq_id     highest-priority pending source
//   debug      debug bus
// ---------------------------------------------------------------------------
module uart_component
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  output logic       rd_busy,
  input  logic       rd_strobe,
  input  logic       wr,
  input  logic       rx_in,
  output logic       tx_out,
  input  logic [2:0] addr,
  output logic [7:0] out_data,
  input  logic [7:0] in_data,
  output logic       irq,
  output logic [2:0] irq_id,
  output logic [7:0] debug
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // Bus access decode. Reads and writes are mutually exclusive through wr.
  logic we_term, we_q, wr_pulse, rd_fire;
  logic wr_ctrl, wr_tx, rd_rx, rd_stat;
  assign we_term  = ~cs & ~wr;
  assign wr_pulse = we_term & ~we_q;
  assign rd_fire  = rd_strobe & ~cs & wr;

  // Receiver
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_frame_err;
  uart_state_e rx_state;

  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk_i       (clock),
    .rst_ni      (reset),
    .rx_i        (rx_in),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid),
    .frame_err_o (rx_frame_err),
    .state_o     (rx_state)
  );

  // Registers
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          rd_busy_q;
  logic          irq_q, irq_d;
  logic [2:0]    irq_id_q, irq_id_d;

  logic       tx_busy, tx_fin;
  logic [7:0] status, rd_mux;
  logic       err_p, rx_p, tx_p;

  assign tx_busy = (tx_state_q != IDLE);
  assign wr_ctrl = wr_pulse & (addr == UART_CTRL);
  assign wr_tx   = wr_pulse & (addr == UART_TX) & ~tx_busy;
  assign rd_rx   = rd_fire & (addr == UART_RX);
  assign rd_stat = rd_fire & (addr == UART_CTRL);

  always_comb begin
    status               = 8'h00;
    status[ST_RX_READY]  = rx_ready_q;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_RX_IE]     = rx_ie_q;
    status[ST_TX_IE]     = tx_ie_q;
    case (addr)
      UART_CTRL: rd_mux = status;
      UART_RX:   rd_mux = rx_data_q;
      default:   rd_mux = 8'h00;
    endcase
  end

  // Transmitter: tx_out is registered so the line never glitches
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_fin     = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (wr_tx) begin
          tx_state_d = START;
          tx_shift_d = in_data;
          tx_out_d   = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_out_d   = tx_shift_q[0];
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_out_d   = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
          tx_fin     = 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Flags. Clears are applied before sets so a same-edge event is not lost;
  // a read of addr 1 frees the buffer for a byte arriving on the same edge.
  always_comb begin
    rx_ready_d  = rx_ready_q;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_ie_d     = rx_ie_q;
    tx_ie_d     = tx_ie_q;
    tx_done_d   = tx_done_q;
    if (wr_ctrl) begin
      rx_ie_d = in_data[ST_RX_IE];
      tx_ie_d = in_data[ST_TX_IE];
      if (in_data[ST_OVERRUN])   overrun_d   = 1'b0;
      if (in_data[ST_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (rd_rx) rx_ready_d = 1'b0;
    if (rx_valid) begin
      if (rx_ready_q && !rd_rx) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_byte;
        rx_ready_d = 1'b1;
      end
    end
    if (rx_frame_err) frame_err_d = 1'b1;
    if (wr_tx || rd_stat) tx_done_d = 1'b0;
    if (tx_fin) tx_done_d = 1'b1;

    out_data_d = rd_fire ? rd_mux : out_data_q;

    err_p = (overrun_q | frame_err_q) & rx_ie_q;
    rx_p  = rx_ready_q & rx_ie_q;
    tx_p  = tx_done_q & tx_ie_q;
    irq_d = err_p | rx_p | tx_p;
    if (err_p)     irq_id_d = IRQ_ERR;
    else if (rx_p) irq_id_d = IRQ_RX;
    else if (tx_p) irq_id_d = IRQ_TX;
    else           irq_id_d = IRQ_NONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_out_q    <= 1'b1;
      tx_done_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      out_data_q  <= 8'h00;
      rd_busy_q   <= 1'b0;
      irq_q       <= 1'b0;
      irq_id_q    <= IRQ_NONE;
    end else begin
      we_q        <= we_term;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
      tx_done_q   <= tx_done_d;
      rx_ready_q  <= rx_ready_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      out_data_q  <= out_data_d;
      rd_busy_q   <= rd_fire;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign out_data = out_data_q;
  assign rd_busy  = rd_busy_q;
  assign irq      = irq_q;
  assign irq_id   = irq_id_q;

`ifdef UART_DEBUG_EN
  logic [7:0] debug_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) debug_q <= 8'h00;
    else        debug_q <= {rx_state[1:0], tx_state_q[1:0], overrun_q,
                            frame_err_q, tx_busy, rx_ready_q};
  end
  assign debug = debug_q;
`else
  logic unused_dbg;
  assign unused_dbg = ^rx_state;
  assign debug      = 8'h00;
`endif

endmodule

// File: tb/tb_uart_component.sv
`timescale 1ns/1ps
module tb_uart_component;

  localparam int DIV = 417;

  logic       clock = 1'b0;
  logic       reset, cs, rd_busy, rd_strobe, wr, rx_in, tx_out, irq;
  logic [2:0] addr, irq_id;
  logic [7:0] out_data, in_data, debug;

  int n_checks  = 0;
  int n_errors  = 0;
  int tx_frames = 0;
  bit tx_mon_en = 1'b1;

  logic [7:0] exp_q[$];     // expected read data, in issue order
  logic [7:0] tx_exp_q[$];  // expected transmitted bytes

  uart_component dut (
    .clock     (clock),
    .reset     (reset),
    .cs        (cs),
    .rd_busy   (rd_busy),
    .rd_strobe (rd_strobe),
    .wr        (wr),
    .rx_in     (rx_in),
    .tx_out    (tx_out),
    .addr      (addr),
    .out_data  (out_data),
    .in_data   (in_data),
    .irq       (irq),
    .irq_id    (irq_id),
    .debug     (debug)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write_hold(input logic [2:0] a, input logic [7:0] d, input int n);
    @(negedge clock);
    addr = a; in_data = d; cs = 1'b0; wr = 1'b0;
    repeat (n) @(negedge clock);
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus_write_hold(a, d, 1);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] e);
    @(negedge clock);
    addr = a; cs = 1'b0; wr = 1'b1; rd_strobe = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
    rd_strobe = 1'b0; cs = 1'b1;
    check("rd_busy_high", rd_busy, 1);
    @(negedge clock);
    check("rd_busy_low", rd_busy, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    rx_in = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx_in = stop_bit;
    repeat (DIV) @(negedge clock);
    rx_in = 1'b1;
    repeat ($urandom_range(5, 30)) @(negedge clock);
  endtask

  // ---------------- read scoreboard ----------------
  always @(negedge clock) begin
    if (rd_busy === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else                   check("rd_data", out_data, exp_q.pop_front());
    end
  end

  // ---------------- TX monitor ----------------
  initial begin
    logic [7:0] bits;
    forever begin
      @(negedge clock);
      if (tx_mon_en && tx_out === 1'b0) begin
        repeat (DIV / 2) @(negedge clock);
        check("tx_start_bit", tx_out, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clock);
          bits[i] = tx_out;
        end
        repeat (DIV) @(negedge clock);
        check("tx_stop_bit", tx_out, 1);
        tx_frames++;
        if (tx_exp_q.size() == 0) check("tx_unexpected", bits, 8'hxx);
        else                      check("tx_byte", bits, tx_exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cs = 1'b1; wr = 1'b1; rd_strobe = 1'b0;
    addr = 3'd0; in_data = 8'h00; rx_in = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_tx_out", tx_out, 1);
    check("rst_out_data", out_data, 8'h00);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_irq", irq, 0);
    check("rst_irq_id", irq_id, 3'd0);
    check("rst_debug", debug, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_tx_out", tx_out, 1);
    bus_read(3'd0, 8'h00);

    // TX 0x55, status busy mid-frame, second write dropped
    tx_exp_q.push_back(8'h55);
    bus_write(3'd2, 8'h55);
    repeat (3 * DIV) @(negedge clock);
    bus_read(3'd0, 8'h02);
    bus_write(3'd2, 8'hAA);
    repeat (8 * DIV) @(negedge clock);
    bus_read(3'd0, 8'h00);
    check("tx_idle_line", tx_out, 1);

    // RX 0xA3; writes to addr 1 are ignored; unmapped reads return 0
    send_rx(8'hA3, 1'b1);
    bus_read(3'd0, 8'h01);
    bus_write(3'd1, 8'hFF);
    bus_read(3'd0, 8'h01);
    bus_read(3'd2, 8'h00);
    bus_read(3'd5, 8'h00);
    bus_read(3'd1, 8'hA3);
    bus_read(3'd0, 8'h00);

    // Overrun then framing error, then clear both
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(3'd0, 8'h05);
    bus_read(3'd1, 8'h11);
    send_rx(8'h33, 1'b0);
    bus_read(3'd0, 8'h0C);
    bus_write(3'd0, 8'h0C);
    bus_read(3'd0, 8'h00);

    // Interrupts
    bus_write(3'd0, 8'h30);
    repeat (3) @(negedge clock);
    check("irq_idle_en", irq, 0);
    send_rx(8'h7E, 1'b1);
    check("irq_rx", irq, 1);
    check("irq_id_rx", irq_id, 3'd1);
    bus_read(3'd1, 8'h7E);
    check("irq_rx_cleared", irq, 0);
    check("irq_id_cleared", irq_id, 3'd0);
    tx_exp_q.push_back(8'h3C);
    bus_write(3'd2, 8'h3C);
    repeat (10 * DIV + 10) @(negedge clock);
    check("irq_tx", irq, 1);
    check("irq_id_tx", irq_id, 3'd2);
    send_rx(8'h5A, 1'b1);
    check("irq_id_rx_over_tx", irq_id, 3'd1);
    send_rx(8'h00, 1'b0);
    check("irq_err", irq, 1);
    check("irq_id_err", irq_id, 3'd3);
    bus_read(3'd1, 8'h5A);
    check("irq_id_err_held", irq_id, 3'd3);
    bus_write(3'd0, 8'h0C);
    repeat (3) @(negedge clock);
    check("irq_all_off", irq, 0);
    check("irq_id_all_off", irq_id, 3'd0);

    // Long write pulse spanning a whole frame: exactly one frame
    tx_exp_q.push_back(8'hC3);
    bus_write_hold(3'd2, 8'hC3, 10 * DIV + 50);
    repeat (11 * DIV) @(negedge clock);
    bus_read(3'd0, 8'h00);

    // Reset in the middle of a frame returns the line to idle at once
    tx_mon_en = 1'b0;
    bus_write(3'd2, 8'h00);
    repeat (3 * DIV) @(negedge clock);
    check("tx_mid_frame_low", tx_out, 0);
    #2 reset = 1'b0;
    #1 check("tx_async_reset", tx_out, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (DIV) @(negedge clock);
    check("tx_no_resume", tx_out, 1);
    bus_read(3'd0, 8'h00);

    check("tx_frame_count", tx_frames, 3);
    check("tx_q_empty", tx_exp_q.size(), 0);
    check("rd_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
